// File: rtl/wb_merge_queue_if.sv
// Write-back lane requests plus register-file write port and status, bundled
// between the pipeline (master) and the merge queue (slave).
interface wb_merge_queue_if;
  logic        In0Valid;
  logic [4:0]  In0Addr;
  logic [3:0]  In0BE;
  logic [31:0] In0Data;
  logic        In1Valid;
  logic [4:0]  In1Addr;
  logic [3:0]  In1BE;
  logic [31:0] In1Data;
  logic        InReady;
  logic [4:0]  WriteAddr;
  logic [3:0]  WriteEnable;
  logic [31:0] WriteData;
  logic [31:0] PendingMask;
  logic        Empty;

  modport master (
    output In0Valid, In0Addr, In0BE, In0Data,
    output In1Valid, In1Addr, In1BE, In1Data,
    input  InReady, WriteAddr, WriteEnable, WriteData, PendingMask, Empty
  );

  modport slave (
    input  In0Valid, In0Addr, In0BE, In0Data,
    input  In1Valid, In1Addr, In1BE, In1Data,
    output InReady, WriteAddr, WriteEnable, WriteData, PendingMask, Empty
  );
endinterface

// File: rtl/wb_merge_queue.sv
// Merges two write-back lanes into one in-order register-file write stream,
// buffering overflow in a small FIFO and exporting a pending-register mask.
module wb_merge_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic              Clk,
  input logic              Clr_n,
  wb_merge_queue_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } item_t;

  item_t            mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  item_t            out_q, out_d;

  logic             in_ready;
  logic             eff0, eff1, merge;
  item_t            lane0, lane1, merged;
  item_t            item_a, item_b;
  logic [1:0]       n_items;
  logic             pop;
  logic             push0_en, push1_en;
  item_t            push0, push1;
  logic [CntW-1:0]  n_push;
  logic [31:0]      pending;

  assign in_ready = (CntW'(DEPTH) - count_q) >= CntW'(2);

  // Zero address or zero byte-enable lanes are accepted but produce nothing.
  assign eff0  = bus.In0Valid && in_ready && (bus.In0Addr != 5'd0) && (bus.In0BE != 4'd0);
  assign eff1  = bus.In1Valid && in_ready && (bus.In1Addr != 5'd0) && (bus.In1BE != 4'd0);
  assign merge = eff0 && eff1 && (bus.In0Addr == bus.In1Addr);

  assign lane0 = '{addr: bus.In0Addr, be: bus.In0BE, data: bus.In0Data};
  assign lane1 = '{addr: bus.In1Addr, be: bus.In1BE, data: bus.In1Data};

  always_comb begin
    merged      = lane0;
    merged.be   = bus.In0BE | bus.In1BE;
    for (int k = 0; k < 4; k++) begin
      if (bus.In1BE[k]) merged.data[8*k +: 8] = bus.In1Data[8*k +: 8];
    end
  end

  always_comb begin
    item_a  = '0;
    item_b  = '0;
    n_items = 2'd0;
    if (merge) begin
      item_a  = merged;
      n_items = 2'd1;
    end else if (eff0 && eff1) begin
      item_a  = lane0;
      item_b  = lane1;
      n_items = 2'd2;
    end else if (eff0) begin
      item_a  = lane0;
      n_items = 2'd1;
    end else if (eff1) begin
      item_a  = lane1;
      n_items = 2'd1;
    end
  end

  always_comb begin
    out_d    = out_q;
    pop      = 1'b0;
    push0_en = 1'b0;
    push1_en = 1'b0;
    push0    = item_a;
    push1    = item_b;
    if (count_q != '0) begin
      pop      = 1'b1;
      out_d    = mem_q[rd_ptr_q];
      push0_en = (n_items != 2'd0);
      push1_en = (n_items == 2'd2);
    end else if (n_items != 2'd0) begin
      // Bypass: first item skips the empty FIFO.
      out_d    = item_a;
      push0_en = (n_items == 2'd2);
      push0    = item_b;
    end else begin
      out_d.be = 4'd0;
    end
    n_push   = CntW'(push0_en) + CntW'(push1_en);
    count_d  = count_q + n_push - CntW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(n_push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push0_en) mem_q[wr_ptr_q] <= push0;
    if (push1_en) mem_q[wr_ptr_q + PtrW'(1)] <= push1;
  end

  always_comb begin
    logic [PtrW-1:0] idx;
    pending = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) pending[mem_q[idx].addr] = 1'b1;
    end
  end

  assign bus.InReady     = in_ready;
  assign bus.WriteAddr   = out_q.addr;
  assign bus.WriteEnable = out_q.be;
  assign bus.WriteData   = out_q.data;
  assign bus.PendingMask = pending;
  assign bus.Empty       = (count_q == '0) && (out_q.be == 4'd0);

endmodule

// File: tb/tb_wb_merge_queue.sv
// Scoreboard bench for wb_merge_queue: expected writes queued at stimulus time,
// popped and compared whenever the register-file write port fires.
module tb_wb_merge_queue;

  logic Clk = 1'b0;
  logic Clr_n = 1'b0;
  always #5 Clk = ~Clk;

  wb_merge_queue_if bus ();

  wb_merge_queue #(.DEPTH(4)) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  writes = 0;
  bit  mon_en = 1'b0;

  // Monitor: every write-port pulse must match the oldest expected write.
  always @(negedge Clk) begin
    if (mon_en && Clr_n && (bus.WriteEnable !== 4'd0)) begin
      wr_t got, exp;
      got = '{a: bus.WriteAddr, be: bus.WriteEnable, d: bus.WriteData};
      writes++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got a=%0d be=%h d=%h, required no write",
                 got.a, got.be, got.d);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL write_order: got a=%0d be=%h d=%h, required a=%0d be=%h d=%h",
                   got.a, got.be, got.d, exp.a, exp.be, exp.d);
        end
      end
    end
  end

  function automatic void push_expected(input logic v0, input logic [4:0] a0,
                                        input logic [3:0] b0, input logic [31:0] d0,
                                        input logic v1, input logic [4:0] a1,
                                        input logic [3:0] b1, input logic [31:0] d1);
    logic e0, e1;
    wr_t  m;
    e0 = v0 && (a0 != 5'd0) && (b0 != 4'd0);
    e1 = v1 && (a1 != 5'd0) && (b1 != 4'd0);
    if (e0 && e1 && (a0 == a1)) begin
      m.a  = a0;
      m.be = b0 | b1;
      for (int k = 0; k < 4; k++) m.d[8*k +: 8] = b1[k] ? d1[8*k +: 8] : d0[8*k +: 8];
      sb.push_back(m);
    end else begin
      if (e0) sb.push_back('{a: a0, be: b0, d: d0});
      if (e1) sb.push_back('{a: a1, be: b1, d: d1});
    end
  endfunction

  task automatic idle_inputs();
    bus.In0Valid = 1'b0; bus.In0Addr = '0; bus.In0BE = '0; bus.In0Data = '0;
    bus.In1Valid = 1'b0; bus.In1Addr = '0; bus.In1BE = '0; bus.In1Data = '0;
  endtask

  // Called 1ns after a negedge; returns 1ns after the following negedge.
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [3:0] b0,
                       input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                       input logic [3:0] b1, input logic [31:0] d1, output bit acc);
    bus.In0Valid = v0; bus.In0Addr = a0; bus.In0BE = b0; bus.In0Data = d0;
    bus.In1Valid = v1; bus.In1Addr = a1; bus.In1BE = b1; bus.In1Data = d1;
    acc = (bus.InReady === 1'b1);
    if (acc) push_expected(v0, a0, b0, d0, v1, a1, b1, d1);
    @(negedge Clk);
    #1;
    idle_inputs();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Clr_n = 1'b0;
    #3;
    tests++;
    if ({bus.WriteEnable, bus.WriteAddr, bus.WriteData} !== 41'd0) begin
      fails++;
      $display("FAIL reset_out: got we=%h a=%0d d=%h, required all 0",
               bus.WriteEnable, bus.WriteAddr, bus.WriteData);
    end
    tests++;
    if ({bus.PendingMask, bus.Empty, bus.InReady} !== {32'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_status: got pm=%h empty=%b ready=%b, required 0/1/1",
               bus.PendingMask, bus.Empty, bus.InReady);
    end
    @(negedge Clk);
    Clr_n = 1'b1;
    mon_en = 1'b1;
    #1;
  endtask

  task automatic test_single();
    bit acc;
    drive(1, 5'd5, 4'hF, 32'h11223344, 0, 5'd0, 4'h0, 32'h0, acc);
    tests++;
    if ({bus.WriteAddr, bus.WriteEnable, bus.WriteData} !== {5'd5, 4'hF, 32'h11223344}) begin
      fails++;
      $display("FAIL single_latency: got a=%0d be=%h d=%h, required a=5 be=f d=11223344",
               bus.WriteAddr, bus.WriteEnable, bus.WriteData);
    end
    tests++;
    if (bus.PendingMask !== 32'd0) begin
      fails++;
      $display("FAIL single_pending: got %h, required 0", bus.PendingMask);
    end
    settle(1);
    tests++;
    if (bus.Empty !== 1'b1) begin
      fails++;
      $display("FAIL single_empty: got %b, required 1", bus.Empty);
    end
  endtask

  task automatic test_merge();
    bit acc;
    int w0;
    w0 = writes;
    drive(1, 5'd3, 4'h3, 32'hAAAABBBB, 1, 5'd3, 4'hC, 32'hCCCCDDDD, acc);
    tests++;
    if ({bus.WriteEnable, bus.WriteData} !== {4'hF, 32'hCCCCBBBB}) begin
      fails++;
      $display("FAIL merge_a: got be=%h d=%h, required be=f d=ccccbbbb",
               bus.WriteEnable, bus.WriteData);
    end
    drive(1, 5'd3, 4'hF, 32'h12345678, 1, 5'd3, 4'h1, 32'h000000EE, acc);
    tests++;
    if ({bus.WriteEnable, bus.WriteData} !== {4'hF, 32'h123456EE}) begin
      fails++;
      $display("FAIL merge_b: got be=%h d=%h, required be=f d=123456ee",
               bus.WriteEnable, bus.WriteData);
    end
    settle(2);
    tests++;
    if (writes - w0 != 2) begin
      fails++;
      $display("FAIL merge_count: got %0d writes, required 2", writes - w0);
    end
  endtask

  task automatic test_pair();
    bit acc;
    drive(1, 5'd7, 4'hF, 32'h07070707, 1, 5'd9, 4'hF, 32'h09090909, acc);
    tests++;
    if ({bus.WriteAddr, bus.PendingMask} !== {5'd7, 32'h0000_0200}) begin
      fails++;
      $display("FAIL pair_first: got a=%0d pm=%h, required a=7 pm=00000200",
               bus.WriteAddr, bus.PendingMask);
    end
    settle(1);
    tests++;
    if ({bus.WriteAddr, bus.PendingMask} !== {5'd9, 32'h0}) begin
      fails++;
      $display("FAIL pair_second: got a=%0d pm=%h, required a=9 pm=0",
               bus.WriteAddr, bus.PendingMask);
    end
    settle(1);
  endtask

  task automatic test_drop();
    bit acc;
    int w0;
    w0 = writes;
    drive(1, 5'd0, 4'hF, 32'hDEADBEEF, 1, 5'd4, 4'h0, 32'hFEEDFACE, acc);
    tests++;
    if ({bus.WriteEnable, bus.PendingMask} !== 36'd0) begin
      fails++;
      $display("FAIL drop_none: got be=%h pm=%h, required 0/0", bus.WriteEnable, bus.PendingMask);
    end
    drive(1, 5'd0, 4'hF, 32'h1, 1, 5'd6, 4'h5, 32'h66666666, acc);
    settle(2);
    tests++;
    if (writes - w0 != 1 || bus.Empty !== 1'b1) begin
      fails++;
      $display("FAIL drop_count: got %0d writes empty=%b, required 1 write empty=1",
               writes - w0, bus.Empty);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, saw_stall;
    int cnt, k, pops, pushes, guard;
    logic [4:0] a0;
    cnt = 0; k = 0; saw_stall = 0; guard = 0;
    while (k < 16 && guard < 60) begin
      tests++;
      if (bus.InReady !== ((4 - cnt) >= 2)) begin
        fails++;
        $display("FAIL b2b_ready: got %b with model count %0d", bus.InReady, cnt);
      end
      if (bus.InReady !== 1'b1) saw_stall = 1;
      a0 = 5'(1 + (2 * k) % 30);
      drive(1, a0, 4'hF, $urandom, 1, a0 + 5'd1, 4'hF, $urandom, acc);
      pops   = (cnt > 0) ? 1 : 0;
      pushes = !acc ? 0 : ((cnt > 0) ? 2 : 1);
      cnt    = cnt - pops + pushes;
      if (acc) k++;
      guard++;
    end
    guard = 0;
    while (bus.Empty !== 1'b1 && guard < 20) begin
      settle(1);
      guard++;
    end
    tests++;
    if (bus.Empty !== 1'b1 || sb.size() != 0 || !saw_stall) begin
      fails++;
      $display("FAIL b2b_drain: got empty=%b left=%0d stall=%b, required 1/0/1",
               bus.Empty, sb.size(), saw_stall);
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    int w0;
    drive(1, 5'd10, 4'hF, 32'hA0, 1, 5'd11, 4'hF, 32'hB0, acc);
    drive(1, 5'd12, 4'hF, 32'hC0, 1, 5'd13, 4'hF, 32'hD0, acc);
    drive(1, 5'd14, 4'hF, 32'hE0, 1, 5'd15, 4'hF, 32'hF0, acc);
    tests++;
    if (bus.PendingMask !== 32'h0000_E000) begin
      fails++;
      $display("FAIL ares_queued: got pm=%h, required 0000e000", bus.PendingMask);
    end
    #1;
    Clr_n = 1'b0;
    #1;
    tests++;
    if ({bus.WriteEnable, bus.PendingMask, bus.InReady, bus.Empty} !== {36'd0, 2'b11}) begin
      fails++;
      $display("FAIL ares_immediate: got be=%h pm=%h ready=%b empty=%b, required 0/0/1/1",
               bus.WriteEnable, bus.PendingMask, bus.InReady, bus.Empty);
    end
    sb.delete();
    w0 = writes;
    @(negedge Clk);
    Clr_n = 1'b1;
    settle(6);
    tests++;
    if (writes != w0 || bus.Empty !== 1'b1) begin
      fails++;
      $display("FAIL ares_discard: got %0d writes empty=%b, required 0 writes empty=1",
               writes - w0, bus.Empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_pair();
    test_drop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
